// File: rtl/mem_channel_scheduler.sv
// Memory channel scheduler: NUM_CHANNELS independent channel FSMs share NUM_CONSUMERS
// requesters through one round-robin pointer, relaying one read or write per claim.
module mem_channel_scheduler #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_EN      = 1
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,

    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,

    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,

    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_WRITE_WAIT,
        ST_READ_RELAY,
        ST_WRITE_RELAY
    } state_t;

    state_t                 r_state [NUM_CHANNELS];
    logic [PTR_W-1:0]       r_owner [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   r_addr  [NUM_CHANNELS];
    // Holds write data while writing, captured read data while relaying a read.
    logic [DATA_BITS-1:0]   r_data  [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] r_claimed;
    logic [PTR_W-1:0]       r_rr_ptr;

    logic [NUM_CONSUMERS-1:0] w_write_valid;
    logic [NUM_CONSUMERS-1:0] w_pending;
    logic [NUM_CONSUMERS-1:0] w_taken;
    logic [NUM_CONSUMERS-1:0] w_release;
    logic [NUM_CHANNELS-1:0]  w_release_ch;
    logic [NUM_CHANNELS-1:0]  w_grant;
    logic [PTR_W-1:0]         w_grant_idx [NUM_CHANNELS];
    logic [PTR_W-1:0]         w_scan;
    logic [PTR_W-1:0]         w_rr_next;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CONSUMERS) sum = sum - NUM_CONSUMERS;
        return sum[PTR_W-1:0];
    endfunction

    assign w_write_valid = (WRITE_EN != 0) ? consumer_write_valid : '0;
    // Claimed is the registered view, so a consumer released this cycle cannot be re-granted yet.
    assign w_pending     = (consumer_read_valid | w_write_valid) & ~r_claimed;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        w_taken   = '0;
        w_grant   = '0;
        w_scan    = '0;
        w_rr_next = r_rr_ptr;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_grant_idx[c] = '0;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (r_state[c] == ST_IDLE) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    w_scan = wrap_add(r_rr_ptr, i);
                    if (!w_grant[c] && w_pending[w_scan] && !w_taken[w_scan]) begin
                        w_grant[c]      = 1'b1;
                        w_grant_idx[c]  = w_scan;
                        w_taken[w_scan] = 1'b1;
                        w_rr_next       = wrap_add(w_scan, 1);
                    end
                end
            end
        end
    end

    always_comb begin
        w_release    = '0;
        w_release_ch = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                if (r_owner[c] == PTR_W'(k)) begin
                    if ((r_state[c] == ST_READ_RELAY && !consumer_read_valid[k]) ||
                        (r_state[c] == ST_WRITE_RELAY && !w_write_valid[k])) begin
                        w_release[k]    = 1'b1;
                        w_release_ch[c] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the per-channel register arrays are reset too; their contents reach outputs.
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= ST_IDLE;
                r_owner[c] <= '0;
                r_addr[c]  <= '0;
                r_data[c]  <= '0;
            end
            r_claimed <= '0;
            r_rr_ptr  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every channel sees the same pre-edge state.
            r_claimed <= (r_claimed & ~w_release) | w_taken;
            r_rr_ptr  <= w_rr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (r_state[c])
                    ST_IDLE: begin
                        if (w_grant[c]) begin
                            r_owner[c] <= w_grant_idx[c];
                            if (consumer_read_valid[w_grant_idx[c]]) begin
                                r_addr[c]  <= consumer_read_address[w_grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                                r_state[c] <= ST_READ_WAIT;
                            end else begin
                                r_addr[c]  <= consumer_write_address[w_grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                                r_data[c]  <= consumer_write_data[w_grant_idx[c]*DATA_BITS +: DATA_BITS];
                                r_state[c] <= ST_WRITE_WAIT;
                            end
                        end
                    end
                    ST_READ_WAIT: begin
                        if (mem_read_ready[c]) begin
                            r_data[c]  <= mem_read_data[c*DATA_BITS +: DATA_BITS];
                            r_state[c] <= ST_READ_RELAY;
                        end
                    end
                    ST_WRITE_WAIT: begin
                        if (mem_write_ready[c]) r_state[c] <= ST_WRITE_RELAY;
                    end
                    ST_READ_RELAY, ST_WRITE_RELAY: begin
                        if (w_release_ch[c]) r_state[c] <= ST_IDLE;
                    end
                    default: r_state[c] <= ST_IDLE;
                endcase
            end
        end
    end

    // Outputs are decoded from state so non-owning channels contribute nothing.
    always_comb begin
        mem_read_valid       = '0;
        mem_read_address     = '0;
        mem_write_valid      = '0;
        mem_write_address    = '0;
        mem_write_data       = '0;
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (r_state[c] == ST_READ_WAIT) begin
                mem_read_valid[c]                         = 1'b1;
                mem_read_address[c*ADDR_BITS +: ADDR_BITS] = r_addr[c];
            end
            if (WRITE_EN != 0 && r_state[c] == ST_WRITE_WAIT) begin
                mem_write_valid[c]                          = 1'b1;
                mem_write_address[c*ADDR_BITS +: ADDR_BITS] = r_addr[c];
                mem_write_data[c*DATA_BITS +: DATA_BITS]    = r_data[c];
            end
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                if (r_owner[c] == PTR_W'(k)) begin
                    if (r_state[c] == ST_READ_RELAY) begin
                        consumer_read_ready[k]                     = 1'b1;
                        consumer_read_data[k*DATA_BITS +: DATA_BITS] = r_data[c];
                    end
                    if (WRITE_EN != 0 && r_state[c] == ST_WRITE_RELAY) begin
                        consumer_write_ready[k] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mem_channel_scheduler.md
MEM_CHANNEL_SCHEDULER -- requirements
Module: mem_channel_scheduler

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, memory data width.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 8, number of requesting LSUs/fetchers (N).
REQ-004 SHALL have parameter NUM_CHANNELS, default 4, number of memory channels (M), 1 <= M <= N.
REQ-005 SHALL have parameter WRITE_EN, default 1; 0 ties all write outputs low and ignores write inputs.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have ports consumer_read_valid / consumer_read_ready  in / out  N  per-consumer read request / response strobe.
REQ-009 SHALL have ports consumer_read_address / consumer_read_data  in / out  N*ADDR_BITS / N*DATA_BITS  packed, consumer k at slice k.
REQ-010 SHALL have ports consumer_write_valid / consumer_write_ready  in / out  N  per-consumer write request / ack.
REQ-011 SHALL have ports consumer_write_address / consumer_write_data  in  N*ADDR_BITS / N*DATA_BITS  packed write request.
REQ-012 SHALL have ports mem_read_valid / mem_read_ready  out / in  M  per-channel read request / memory response.
REQ-013 SHALL have ports mem_read_address / mem_read_data  out / in  M*ADDR_BITS / M*DATA_BITS  packed.
REQ-014 SHALL have ports mem_write_valid / mem_write_ready  out / in  M  per-channel write request / ack.
REQ-015 SHALL have ports mem_write_address / mem_write_data  out  M*ADDR_BITS / M*DATA_BITS  packed.

Function
REQ-016 Each channel SHALL run an FSM: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
REQ-017 A consumer SHALL be pending when its read_valid or write_valid is high and it is not claimed by any channel.
REQ-018 Each cycle, IDLE channels SHALL be processed in ascending index order; each claims the first pending consumer found scanning from rr_ptr upward mod N, skipping consumers claimed earlier in the same cycle.
REQ-019 After any grant, rr_ptr SHALL become (last consumer granted that cycle + 1) mod N.
REQ-020 On claim with read_valid high: channel SHALL register address, set claimed[k], go READ_WAIT, assert mem_read_valid next cycle (1-cycle latency).
REQ-021 On claim with only write_valid high: channel SHALL register address and data, go WRITE_WAIT, assert mem_write_valid next cycle; read wins if both valid.
REQ-022 READ_WAIT: mem_read_valid and address SHALL hold until mem_read_ready sampled high; then capture mem_read_data, drop mem_read_valid, go READ_RELAY.
REQ-023 READ_RELAY: consumer_read_ready[k] and consumer_read_data[k] SHALL be driven (asserted the cycle after mem_read_ready) and held until consumer_read_valid[k] sampled low; then deassert next cycle, clear claimed[k], return IDLE.
REQ-024 WRITE_WAIT/WRITE_RELAY SHALL behave identically with mem_write_ready, consumer_write_ready, consumer_write_valid.
REQ-025 A released consumer SHALL NOT be re-granted in the same cycle it is released.
REQ-026 At most one channel SHALL own a consumer; channel outputs of non-owning channels for that consumer SHALL be zero.
REQ-027 mem_*_valid SHALL be high only in the matching WAIT state; consumer_*_ready only in the matching RELAY state.
REQ-028 rr_ptr SHALL wrap N-1 -> 0; $clog2(N) bits, N=1 holds at 0.
REQ-029 Consumer dropping valid during WAIT SHALL NOT abort the memory transaction; RELAY then lasts exactly one cycle.

Reset
REQ-030 reset low SHALL asynchronously force all channels IDLE, claimed=0, rr_ptr=0, and every output (valid, ready, address, data) to 0.
REQ-031 Reset mid-transaction SHALL abandon it without completion or replay; operation resumes on the first rising edge with reset high.

Verification
REQ-032 Single read: consumer 2 read addr 0x10, memory returns 0x5A after 3 cycles -> ch0 mem_read_valid at t+1, consumer_read_ready[2] with data 0x5A one cycle after mem_read_ready, cleared one cycle after valid drops.
REQ-033 Contention: all 8 consumers read in same cycle, M=4 -> consumers 0-3 on ch0-3, rr_ptr=4; consumers 4-7 served next, no consumer granted twice.
REQ-034 Fairness: consumer 0 re-requests continuously while 5 waits -> 5 granted before 0's second grant.
REQ-035 Write: consumer 7 write 0xC3 to 0xFF -> mem_write_address=0xFF, data=0xC3 on one channel; consumer_write_ready[7] after mem_write_ready; rr_ptr wraps to 0.
REQ-036 Reset mid-READ_WAIT -> all outputs 0 immediately, claimed cleared, same request re-granted on ch0 after release.
REQ-037 WRITE_EN=0 with write_valid high -> no mem_write_valid, no consumer_write_ready ever.
